axis_stream_fifo: RTL and testbench

Parametrised AXI4-Stream FIFO with full TVALID/TREADY backpressure on both sides, configurable data width and depth, occupancy and packet-count status, and an optional packet (store-and-forward) mode. It is the next-generation stream pass-through stage, used between stream producers and consumers wherever rate decoupling or whole-packet buffering is needed. All ports are on a single clock domain.

---
 rtl/axis_stream_fifo.sv | 97 +++++++++
 tb/tb_axis_stream_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// AXI4-Stream FIFO with first-word-fall-through output, occupancy/packet status
// and an optional store-and-forward mode that holds output until a packet is complete.
module axis_stream_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic                      S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic [$clog2(DEPTH):0]    FILL_LEVEL,
  output logic [$clog2(DEPTH):0]    PKT_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic [AW:0]   r_pkt;
  logic          r_mid_pkt;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_last;
  logic          w_rd_last;
  logic [EW-1:0] w_rd_entry;

  assign w_full     = (r_fill == FULL_LEVEL);
  assign w_empty    = (r_fill == '0);
  assign w_rd_entry = r_mem[r_rd_ptr];

  assign S_AXIS_TREADY = !ARESET && !w_full;
  // The full term releases packets longer than DEPTH; mid_pkt keeps them draining.
  assign M_AXIS_TVALID = !w_empty &&
                         ((PACKET_MODE == 0) || (r_pkt != '0) || w_full || r_mid_pkt);

  assign M_AXIS_TDATA = w_rd_entry[EW-1 -: DATA_WIDTH];
  assign M_AXIS_TKEEP = w_rd_entry[KW:1];
  assign M_AXIS_TLAST = w_rd_entry[0];
  assign FILL_LEVEL   = r_fill;
  assign PKT_COUNT    = r_pkt;

  assign w_wr      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_rd      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_wr_last = w_wr && S_AXIS_TLAST;
  assign w_rd_last = w_rd && M_AXIS_TLAST;

  // NOTE: the storage array carries no reset; pointers and counters alone define what is valid.
  always_ff @(posedge ACLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= {S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_pkt     <= '0;
      r_mid_pkt <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase

      case ({w_wr_last, w_rd_last})
        2'b10:   r_pkt <= r_pkt + 1'b1;
        2'b01:   r_pkt <= r_pkt - 1'b1;
        default: r_pkt <= r_pkt;
      endcase

      if (w_rd) r_mid_pkt <= !M_AXIS_TLAST;
    end
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: one cut-through and one packet-mode instance,
// each checked against a queue-based scoreboard of accepted input beats.
module tb_axis_stream_fifo;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic ACLK;
  logic ARESET;

  logic [DW-1:0] ct_s_tdata, ct_m_tdata, pm_s_tdata, pm_m_tdata;
  logic [KW-1:0] ct_s_tkeep, ct_m_tkeep, pm_s_tkeep, pm_m_tkeep;
  logic          ct_s_tvalid, ct_s_tready, ct_s_tlast, ct_m_tvalid, ct_m_tready, ct_m_tlast;
  logic          pm_s_tvalid, pm_s_tready, pm_s_tlast, pm_m_tvalid, pm_m_tready, pm_m_tlast;
  logic [LW-1:0] ct_fill, ct_pkt, pm_fill, pm_pkt;

  logic ct_wr, pm_wr;
  beat_t q_ct[$];
  beat_t q_pm[$];
  int n_cmp = 0;
  int n_fail = 0;

  axis_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_ct (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIS_TDATA(ct_s_tdata), .S_AXIS_TKEEP(ct_s_tkeep), .S_AXIS_TVALID(ct_s_tvalid),
    .S_AXIS_TREADY(ct_s_tready), .S_AXIS_TLAST(ct_s_tlast),
    .M_AXIS_TDATA(ct_m_tdata), .M_AXIS_TKEEP(ct_m_tkeep), .M_AXIS_TVALID(ct_m_tvalid),
    .M_AXIS_TREADY(ct_m_tready), .M_AXIS_TLAST(ct_m_tlast),
    .FILL_LEVEL(ct_fill), .PKT_COUNT(ct_pkt)
  );

  axis_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pm (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIS_TDATA(pm_s_tdata), .S_AXIS_TKEEP(pm_s_tkeep), .S_AXIS_TVALID(pm_s_tvalid),
    .S_AXIS_TREADY(pm_s_tready), .S_AXIS_TLAST(pm_s_tlast),
    .M_AXIS_TDATA(pm_m_tdata), .M_AXIS_TKEEP(pm_m_tkeep), .M_AXIS_TVALID(pm_m_tvalid),
    .M_AXIS_TREADY(pm_m_tready), .M_AXIS_TLAST(pm_m_tlast),
    .FILL_LEVEL(pm_fill), .PKT_COUNT(pm_pkt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score reads against the queues, log writes, then advance past the edge.
  task automatic cycle();
    beat_t b;
    #1;
    ct_wr = ct_s_tvalid && ct_s_tready;
    pm_wr = pm_s_tvalid && pm_s_tready;
    if (ct_m_tvalid && ct_m_tready) begin
      check("ct_read_has_expected", q_ct.size() != 0, 1'b1);
      if (q_ct.size() != 0) begin
        b = q_ct.pop_front();
        check("ct_beat", {ct_m_tdata, ct_m_tkeep, ct_m_tlast}, b);
      end
    end
    if (pm_m_tvalid && pm_m_tready) begin
      check("pm_read_has_expected", q_pm.size() != 0, 1'b1);
      if (q_pm.size() != 0) begin
        b = q_pm.pop_front();
        check("pm_beat", {pm_m_tdata, pm_m_tkeep, pm_m_tlast}, b);
      end
    end
    if (ct_wr) q_ct.push_back('{ct_s_tdata, ct_s_tkeep, ct_s_tlast});
    if (pm_wr) q_pm.push_back('{pm_s_tdata, pm_s_tkeep, pm_s_tlast});
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int acc;
    int cyc;
    int sent;
    int stall;
    int max_fill;
    bit released;

    ARESET = 1'b1;
    ct_s_tdata = '0; ct_s_tkeep = '0; ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
    pm_s_tdata = '0; pm_s_tkeep = '0; pm_s_tvalid = 1'b0; pm_s_tlast = 1'b0; pm_m_tready = 1'b0;
    ct_wr = 1'b0; pm_wr = 1'b0;

    // Reset state
    cycle();
    cycle();
    check("rst_ct_tready_low", ct_s_tready, 1'b0);
    check("rst_pm_tready_low", pm_s_tready, 1'b0);
    ARESET = 1'b0;
    cycle();
    check("rst_ct_tready", ct_s_tready, 1'b1);
    check("rst_ct_fill", ct_fill, 0);
    check("rst_ct_pkt", ct_pkt, 0);
    check("rst_ct_tvalid", ct_m_tvalid, 1'b0);
    check("rst_pm_tvalid", pm_m_tvalid, 1'b0);

    // Cut-through: 5 beats, each visible one cycle after its write
    ct_m_tready = 1'b1;
    ct_s_tkeep = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      ct_s_tvalid = 1'b1;
      ct_s_tdata = 64'(k);
      ct_s_tlast = (k == 5);
      cycle();
      check($sformatf("lat_valid_%0d", k), ct_m_tvalid, 1'b1);
      check($sformatf("lat_data_%0d", k), ct_m_tdata, 64'(k));
    end
    ct_s_tvalid = 1'b0;
    ct_s_tlast = 1'b0;
    cycle();
    check("lat_fill_zero", ct_fill, 0);
    check("lat_tvalid_zero", ct_m_tvalid, 1'b0);
    check("lat_sb_empty", q_ct.size(), 0);

    // Cut-through: fill to full, then release one beat
    ct_m_tready = 1'b0;
    ct_s_tvalid = 1'b1;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      ct_s_tdata = 64'(100 + acc);
      cycle();
      if (ct_wr) acc++;
    end
    check("full_accepted", acc, 16);
    check("full_tready", ct_s_tready, 1'b0);
    check("full_fill", ct_fill, 16);
    ct_m_tready = 1'b1;
    cycle();
    ct_m_tready = 1'b0;
    check("full_tready_after_pulse", ct_s_tready, 1'b1);
    check("full_fill_after_pulse", ct_fill, 15);
    ct_s_tvalid = 1'b0;
    ct_m_tready = 1'b1;
    cyc = 0;
    while (q_ct.size() != 0 && cyc < 100) begin
      cycle();
      cyc++;
    end
    check("full_drain_no_timeout", cyc < 100, 1'b1);
    check("full_drain_fill", ct_fill, 0);

    // Cut-through: random handshakes, random TKEEP including 0x00
    sent = 0; cyc = 0; max_fill = 0;
    ct_s_tvalid = 1'b0;
    while ((sent < 1000 || q_ct.size() != 0) && cyc < 20000) begin
      if (!ct_s_tvalid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        ct_s_tdata = {$urandom, $urandom};
        ct_s_tkeep = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        ct_s_tlast = ($urandom_range(0, 7) == 0);
        ct_s_tvalid = 1'b1;
      end
      ct_m_tready = ($urandom_range(0, 1) == 1);
      cycle();
      if (ct_wr) begin
        sent++;
        ct_s_tvalid = 1'b0;
      end
      if (int'(ct_fill) > max_fill) max_fill = int'(ct_fill);
      cyc++;
    end
    check("rnd_no_timeout", cyc < 20000, 1'b1);
    check("rnd_sent", sent, 1000);
    check("rnd_drained", q_ct.size(), 0);
    check("rnd_fill_in_range", max_fill <= 16, 1'b1);
    check("rnd_end_fill", ct_fill, 0);
    check("rnd_end_pkt", ct_pkt, 0);
    ct_m_tready = 1'b0;
    ct_s_tlast = 1'b0;

    // Packet mode: 4-beat packet with idle gaps, held until TLAST is stored
    pm_m_tready = 1'b1;
    pm_s_tkeep = 8'h0F;
    for (int k = 1; k <= 4; k++) begin
      pm_s_tvalid = 1'b1;
      pm_s_tdata = 64'(200 + k);
      pm_s_tlast = (k == 4);
      cycle();
      check($sformatf("pm4_wr_%0d", k), pm_wr, 1'b1);
      pm_s_tvalid = 1'b0;
      if (k < 4) begin
        check($sformatf("pm4_hold_%0d", k), pm_m_tvalid, 1'b0);
        cycle();
        check($sformatf("pm4_hold_idle_%0d", k), pm_m_tvalid, 1'b0);
      end
    end
    pm_s_tlast = 1'b0;
    check("pm4_release", pm_m_tvalid, 1'b1);
    check("pm4_pkt_one", pm_pkt, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("pm4_b2b_%0d", k), pm_m_tvalid, 1'b1);
      cycle();
    end
    check("pm4_pkt_zero", pm_pkt, 0);
    check("pm4_fill_zero", pm_fill, 0);
    check("pm4_tvalid_zero", pm_m_tvalid, 1'b0);

    // Packet mode: 20-beat packet released by full occupancy
    acc = 0; cyc = 0; stall = 0; released = 1'b0;
    pm_s_tkeep = 8'hA5;
    while ((acc < 20 || q_pm.size() != 0) && cyc < 200) begin
      pm_s_tvalid = (acc < 20);
      pm_s_tdata = 64'(400 + acc);
      pm_s_tlast = (acc == 19);
      #1;
      if (!released && pm_m_tvalid) begin
        released = 1'b1;
        check("pm20_release_fill", pm_fill, 16);
      end
      if (released && q_pm.size() != 0 && !pm_m_tvalid) stall++;
      cycle();
      if (pm_wr) acc++;
      cyc++;
    end
    pm_s_tvalid = 1'b0;
    pm_s_tlast = 1'b0;
    check("pm20_no_timeout", cyc < 200, 1'b1);
    check("pm20_released", released, 1'b1);
    check("pm20_written", acc, 20);
    check("pm20_no_stall", stall, 0);
    check("pm20_fill_zero", pm_fill, 0);
    check("pm20_pkt_zero", pm_pkt, 0);

    // mid_pkt must be clear: a new partial packet stays held
    for (int k = 0; k < 7; k++) begin
      pm_s_tvalid = 1'b1;
      pm_s_tdata = 64'(600 + k);
      cycle();
      check($sformatf("mid_hold_%0d", k), pm_m_tvalid, 1'b0);
    end
    pm_s_tvalid = 1'b0;
    check("mid_fill_seven", pm_fill, 7);

    // Reset mid-packet discards everything stored
    ARESET = 1'b1;
    #1;
    check("rst2_tready_low", pm_s_tready, 1'b0);
    cycle();
    ARESET = 1'b0;
    check("rst2_fill", pm_fill, 0);
    check("rst2_pkt", pm_pkt, 0);
    check("rst2_tvalid", pm_m_tvalid, 1'b0);
    q_pm.delete();
    for (int k = 0; k < 2; k++) begin
      pm_s_tvalid = 1'b1;
      pm_s_tdata = 64'(800 + k);
      pm_s_tkeep = 8'h00;
      pm_s_tlast = (k == 1);
      cycle();
    end
    pm_s_tvalid = 1'b0;
    pm_s_tlast = 1'b0;
    cyc = 0;
    while (q_pm.size() != 0 && cyc < 50) begin
      cycle();
      cyc++;
    end
    check("rst2_drain_no_timeout", cyc < 50, 1'b1);
    check("rst2_fill_end", pm_fill, 0);
    check("rst2_tvalid_end", pm_m_tvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
